// File: rtl/btb_if.sv
// Fetch/resolve port bundle for branch_target_buffer: IF-stage lookup,
// ID-stage training feedback and the invalidate-sweep handshake.
interface btb_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              update_en;
  logic [ADDR_W-1:0] update_pc;
  logic              update_taken;
  logic [ADDR_W-1:0] update_target;
  logic              invalidate_req;
  logic              busy;

  modport master (
    output lookup_pc, update_en, update_pc, update_taken, update_target, invalidate_req,
    input  pred_hit, pred_taken, pred_target, busy
  );

  modport slave (
    input  lookup_pc, update_en, update_pc, update_taken, update_target, invalidate_req,
    output pred_hit, pred_taken, pred_target, busy
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with saturating direction counters and a sequential invalidate sweep.
// Optional BTB_STATS_EN adds lookup/hit/mispredict counters.
//
// state | meaning
// IDLE  | lookups and training active
// SWEEP | clearing one valid bit per cycle, lookups miss, training dropped
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  btb_if.slave        btb
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  state_t            state;
  logic              busy_q;
  logic [IDX_W-1:0]  sweep_idx;
  logic [ENTRIES-1:0] valid_q;
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, u_pred, upd_ok;
  logic             unused_pc_bits;

  assign l_idx = btb.lookup_pc[IDX_W+1:2];
  assign l_tag = btb.lookup_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = btb.update_pc[IDX_W+1:2];
  assign u_tag = btb.update_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = ^btb.update_pc[1:0];

  // Lookup sees only registered state: no bypass from a same-cycle update.
  assign l_hit  = ~busy_q & valid_q[l_idx] & (tag_q[l_idx] == l_tag);
  assign u_hit  = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign u_pred = u_hit & cnt_q[u_idx][CNT_W-1];
  assign upd_ok = btb.update_en & ~busy_q;

  assign btb.pred_hit    = l_hit;
  assign btb.pred_taken  = l_hit & cnt_q[l_idx][CNT_W-1];
  assign btb.pred_target = btb.pred_taken ? target_q[l_idx] : btb.lookup_pc + ADDR_W'(4);
  assign btb.busy        = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      sweep_idx <= '0;
      valid_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_ok) begin
            if (u_hit) begin
              if (btb.update_taken && cnt_q[u_idx] != CNT_MAX)
                cnt_q[u_idx] <= cnt_q[u_idx] + CNT_W'(1);
              else if (!btb.update_taken && cnt_q[u_idx] != '0)
                cnt_q[u_idx] <= cnt_q[u_idx] - CNT_W'(1);
            end else if (btb.update_taken) begin
              valid_q[u_idx] <= 1'b1;
              cnt_q[u_idx]   <= CNT_WEAK;
            end
          end
          if (btb.invalidate_req) begin
            state     <= SWEEP;
            busy_q    <= 1'b1;
            sweep_idx <= '0;
          end
        end
        SWEEP: begin
          valid_q[sweep_idx] <= 1'b0;
          sweep_idx          <= sweep_idx + IDX_W'(1);
          if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Tags and targets carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (upd_ok && btb.update_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= btb.update_target;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else if (!busy_q && btb.invalidate_req) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (!busy_q) stat_lookups <= stat_lookups + 32'd1;
      if (l_hit)   stat_hits    <= stat_hits + 32'd1;
      if (upd_ok && (u_pred != btb.update_taken))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16, ADDR_W=32, CNT_W=2).
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  btb_if #(.ADDR_W(32)) bus ();

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  branch_target_buffer #(.ENTRIES(16), .ADDR_W(32), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btb   (bus)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ue;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] look;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } vec_t;

  vec_t vec [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt);
    bus.lookup_pc = pc;
    #1;
    chk({name, "_hit"},    32'(bus.pred_hit),   32'(hit));
    chk({name, "_taken"},  32'(bus.pred_taken), 32'(taken));
    chk({name, "_target"}, bus.pred_target,     tgt);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.update_en     = 1'b1;
    bus.update_pc     = pc;
    bus.update_taken  = taken;
    bus.update_target = tgt;
    tick();
    bus.update_en = 1'b0;
  endtask

  initial begin
    int n;
    vec[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,    32'h40,       1'b0, 1'b0, 32'h44};
    vec[1]  = '{1'b1, 32'h40,       1'b1, 32'h100,  32'h40,       1'b1, 1'b1, 32'h100};
    vec[2]  = '{1'b1, 32'h40,       1'b0, 32'h0,    32'h40,       1'b1, 1'b0, 32'h44};
    vec[3]  = '{1'b1, 32'h40,       1'b0, 32'h0,    32'h40,       1'b1, 1'b0, 32'h44};
    vec[4]  = '{1'b1, 32'h40,       1'b0, 32'h0,    32'h40,       1'b1, 1'b0, 32'h44};
    vec[5]  = '{1'b1, 32'h40,       1'b1, 32'h200,  32'h40,       1'b1, 1'b0, 32'h44};
    vec[6]  = '{1'b1, 32'h40,       1'b1, 32'h300,  32'h40,       1'b1, 1'b1, 32'h300};
    vec[7]  = '{1'b1, 32'h40,       1'b1, 32'h300,  32'h40,       1'b1, 1'b1, 32'h300};
    vec[8]  = '{1'b1, 32'h40,       1'b1, 32'h300,  32'h40,       1'b1, 1'b1, 32'h300};
    vec[9]  = '{1'b1, 32'h40,       1'b0, 32'h0,    32'h40,       1'b1, 1'b1, 32'h300};
    vec[10] = '{1'b1, 32'h40,       1'b0, 32'h0,    32'h40,       1'b1, 1'b0, 32'h44};
    vec[11] = '{1'b1, 32'h80,       1'b1, 32'h500,  32'h40,       1'b0, 1'b0, 32'h44};
    vec[12] = '{1'b0, 32'h0,        1'b0, 32'h0,    32'h80,       1'b1, 1'b1, 32'h500};
    vec[13] = '{1'b1, 32'hC0,       1'b0, 32'h0,    32'h80,       1'b1, 1'b1, 32'h500};
    vec[14] = '{1'b0, 32'h0,        1'b0, 32'h0,    32'hC0,       1'b0, 1'b0, 32'hC4};
    vec[15] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,    32'hFFFFFFFC, 1'b0, 1'b0, 32'h0};
    vec[16] = '{1'b1, 32'h44,       1'b1, 32'h1000, 32'h44,       1'b1, 1'b1, 32'h1000};
    vec[17] = '{1'b0, 32'h0,        1'b0, 32'h0,    32'h46,       1'b1, 1'b1, 32'h1000};
    vec[18] = '{1'b1, 32'h80,       1'b0, 32'h0,    32'h80,       1'b1, 1'b0, 32'h84};

    bus.lookup_pc      = 32'h40;
    bus.update_en      = 1'b0;
    bus.update_pc      = '0;
    bus.update_taken   = 1'b0;
    bus.update_target  = '0;
    bus.invalidate_req = 1'b0;
    #2;
    look("in_reset", 32'h40, 1'b0, 1'b0, 32'h44);
    chk("in_reset_busy", 32'(bus.busy), 32'h0);
    #10 rst_n = 1'b1;
    tick();
    chk("post_reset_busy", 32'(bus.busy), 32'h0);

    for (int i = 0; i < 19; i++) begin
      bus.update_en     = vec[i].ue;
      bus.update_pc     = vec[i].upc;
      bus.update_taken  = vec[i].ut;
      bus.update_target = vec[i].utgt;
      tick();
      bus.update_en = 1'b0;
      look($sformatf("vec%0d", i), vec[i].look, vec[i].hit, vec[i].taken, vec[i].tgt);
    end

    // Same-cycle update and lookup: lookup must see the old (empty) entry.
    bus.update_en     = 1'b1;
    bus.update_pc     = 32'h48;
    bus.update_taken  = 1'b1;
    bus.update_target = 32'h700;
    look("nobypass_pre", 32'h48, 1'b0, 1'b0, 32'h4C);
    tick();
    bus.update_en = 1'b0;
    look("nobypass_post", 32'h48, 1'b1, 1'b1, 32'h700);

    // Invalidate sweep with dropped update and ignored re-request.
    bus.invalidate_req = 1'b1;
    bus.lookup_pc      = 32'h44;
    tick();
    bus.invalidate_req = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      n++;
      chk($sformatf("sweep_hit_c%0d", k), 32'(bus.pred_hit), 32'h0);
      chk($sformatf("sweep_tgt_c%0d", k), bus.pred_target, 32'h48);
      bus.update_en      = (k == 4);
      bus.update_pc      = 32'h100;
      bus.update_taken   = 1'b1;
      bus.update_target  = 32'h900;
      bus.invalidate_req = (k == 2);
      tick();
      bus.update_en      = 1'b0;
      bus.invalidate_req = 1'b0;
    end
    chk("sweep_busy_cycles", 32'(n), 32'd16);
    look("after_sweep_44",  32'h44,  1'b0, 1'b0, 32'h48);
    look("after_sweep_80",  32'h80,  1'b0, 1'b0, 32'h84);
    look("after_sweep_48",  32'h48,  1'b0, 1'b0, 32'h4C);
    look("after_sweep_100", 32'h100, 1'b0, 1'b0, 32'h104);

    // Reset in the middle of a sweep.
    train(32'h7C, 1'b1, 32'hA00);
    look("pre_sweep2_7c", 32'h7C, 1'b1, 1'b1, 32'hA00);
    bus.invalidate_req = 1'b1;
    tick();
    bus.invalidate_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("sweep2_busy_c7", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(bus.busy), 32'h0);
    look("midreset_7c", 32'h7C, 1'b0, 1'b0, 32'h80);
    #8 rst_n = 1'b1;
    tick();
    chk("post_midreset_busy", 32'(bus.busy), 32'h0);
    look("post_midreset_7c", 32'h7C, 1'b0, 1'b0, 32'h80);
    train(32'h7C, 1'b1, 32'hB00);
    chk("post_midreset_idle", 32'(bus.busy), 32'h0);
    look("post_midreset_train", 32'h7C, 1'b1, 1'b1, 32'hB00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
